fn_sweep_ctrl: RTL and testbench



---
 rtl/fn_sweep_pkg.sv | 15 +
 rtl/fn_sweep_ctrl.sv | 116 +++++++++++
 tb/tb_fn_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fn_sweep_pkg.sv
// Shared constants for the logic-function sweep sequencer: FSM encoding and
// vector-space sizing.
package fn_sweep_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t WAIT   = 2'd1;
  localparam state_t SAMPLE = 2'd2;
  localparam state_t DONE   = 2'd3;

  localparam int N_VEC = 16;
  localparam int IDX_W = 4;

endpackage

// File: rtl/fn_sweep_ctrl.sv
// Drives a 4-input combinational unit through all 16 vectors, samples its
// output after SETTLE cycles, and reports the measured truth table vs expected.
module fn_sweep_ctrl
  import fn_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_cnt,
  output logic        pass,
  output logic [1:0]  state_dbg
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VEC - 1);
  localparam logic [4:0] MM_MAX = 5'(N_VEC);

  state_t            state_q;
  state_t            state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        cnt_q;
  logic [15:0]       exp_q;
  logic [15:0]       table_q;
  logic [4:0]        mm_q;
  logic              pass_q;
  logic              miss;

  // Handshake: a sweep is accepted only when start=1 is seen in IDLE; done is
  // a single-cycle pulse and busy covers every non-IDLE cycle, so requesters
  // must wait for busy=0 before their next start can be taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = SAMPLE;
      SAMPLE:  state_d = (idx_q == LAST_IDX) ? DONE : WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      WAIT, SAMPLE: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign miss = f_in ^ exp_q[idx_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mm_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            exp_q   <= expected;
            table_q <= '0;
            mm_q    <= '0;
            pass_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= SETTLE_LD;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        SAMPLE: begin
          table_q[idx_q] <= f_in;
          if (miss && mm_q != MM_MAX) mm_q <= mm_q + 5'd1;
          // pass is resolved here so it is already valid during the DONE cycle
          if (idx_q == LAST_IDX) begin
            pass_q <= (mm_q == 5'd0) && !miss;
          end else begin
            idx_q <= idx_q + 1'b1;
            cnt_q <= SETTLE_LD;
          end
        end
        default: ;
      endcase
    end
  end

  // idx is held after a sweep, so abcd stays at 15 until the next start
  assign abcd         = idx_q;
  assign table_out    = table_q;
  assign mismatch_cnt = mm_q;
  assign pass         = pass_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_fn_sweep_ctrl.sv
// Bench for fn_sweep_ctrl: NAND-NAND unit (truth table 16'h1894) on a SETTLE=1
// and a SETTLE=3 instance, with a queue-based scoreboard on the done pulse.
module tb_fn_sweep_ctrl;

  localparam logic [15:0] TT_UNIT = 16'h1894;
  localparam int W = 54;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A (SETTLE=1) and DUT B (SETTLE=3)
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] exp_a = '0, exp_b = '0;
  logic        one_a = 1'b0;
  logic        f_a, f_b;
  logic [3:0]  abcd_a, abcd_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [15:0] tbl_a, tbl_b;
  logic [4:0]  mm_a, mm_b;
  logic [1:0]  st_a, st_b;

  fn_sweep_ctrl #(.SETTLE(1)) u_dut_a (
    .clk(clk), .reset(rst), .start(start_a), .expected(exp_a), .f_in(f_a),
    .abcd(abcd_a), .busy(busy_a), .done(done_a), .table_out(tbl_a),
    .mismatch_cnt(mm_a), .pass(pass_a), .state_dbg(st_a)
  );

  fn_sweep_ctrl #(.SETTLE(3)) u_dut_b (
    .clk(clk), .reset(rst), .start(start_b), .expected(exp_b), .f_in(f_b),
    .abcd(abcd_b), .busy(busy_b), .done(done_b), .table_out(tbl_b),
    .mismatch_cnt(mm_b), .pass(pass_b), .state_dbg(st_b)
  );

  // Gate-level NAND-NAND units: minterms 2, 4, 7, 11, 12
  wire [3:0] v_in [2];
  wire [1:0] unit_o;
  assign v_in[0] = abcd_a;
  assign v_in[1] = abcd_b;

  for (genvar u = 0; u < 2; u++) begin : g_unit
    wire a = v_in[u][3], b = v_in[u][2], c = v_in[u][1], d = v_in[u][0];
    wire na, nb, nc, nd, p2, p4, p7, p11, p12;
    not g_na (na, a);
    not g_nb (nb, b);
    not g_nc (nc, c);
    not g_nd (nd, d);
    nand g_p2  (p2,  na, nb, c,  nd);
    nand g_p4  (p4,  na, b,  nc, nd);
    nand g_p7  (p7,  na, b,  c,  d);
    nand g_p11 (p11, a,  nb, c,  d);
    nand g_p12 (p12, a,  b,  nc, nd);
    nand g_out (unit_o[u], p2, p4, p7, p11, p12);
  end

  // B's unit has two cycles of output delay
  logic fb_d1 = 1'b0, fb_d2 = 1'b0;
  always @(posedge clk) begin
    fb_d1 <= unit_o[1];
    fb_d2 <= fb_d1;
  end
  assign f_b = fb_d2;
  assign f_a = one_a ? 1'b1 : unit_o[0];

  // Scoreboard: {done_cycle[31:0], table[15:0], mismatch[4:0], pass}
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int done_a_cnt = 0;
  int done_b_cnt = 0;
  int b_c0 = 0;
  logic b_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [15:0] e, input logic one, input int c0, input int settle);
    logic [15:0] t;
    logic [4:0]  mm;
    t  = one ? 16'hFFFF : TT_UNIT;
    mm = 5'($countones(t ^ e));
    return {32'(c0 + 16 * (settle + 1) + 1), t, mm, (mm == 5'd0)};
  endfunction

  task automatic compare_done(input string tag, input logic [W-1:0] e, input logic [15:0] t,
                              input logic [4:0] mm, input logic ps);
    chk({tag, "_done_cycle"}, 32'(cyc), e[53:22]);
    chk({tag, "_table"}, 32'(t), 32'(e[21:6]));
    chk({tag, "_mismatch"}, 32'(mm), 32'(e[5:1]));
    chk({tag, "_pass"}, 32'(ps), 32'(e[0]));
  endtask

  // Monitors
  always @(negedge clk) begin
    if (!rst && done_a) begin
      done_a_cnt++;
      if (exp_a_q.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
      else compare_done("a", exp_a_q.pop_front(), tbl_a, mm_a, pass_a);
    end
    if (!rst && done_b) begin
      done_b_cnt++;
      if (exp_b_q.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
      else compare_done("b", exp_b_q.pop_front(), tbl_b, mm_b, pass_b);
    end
    if (!rst && b_active) begin
      int t;
      t = cyc - b_c0 - 1;
      if (t >= 0 && t < 64) chk("b_abcd_hold", 32'(abcd_b), 32'(t / 4));
    end
  end

  // Drivers
  task automatic go_a(input logic [15:0] e, input logic one);
    @(negedge clk);
    exp_a   = e;
    one_a   = one;
    start_a = 1'b1;
    exp_a_q.push_back(model(e, one, cyc, 1));
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (sel_b ? done_b : done_a) seen = 1'b1;
    end
    if (!seen) chk(sel_b ? "b_done_timeout" : "a_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_abcd_a(input logic [3:0] v);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (abcd_a == v && busy_a) seen = 1'b1;
    end
    if (!seen) chk("a_abcd_wait_timeout", 32'(abcd_a), 32'(v));
  endtask

  task automatic chk_zero(input string tag, input logic [3:0] ab, input logic bz, input logic dn,
                          input logic [15:0] t, input logic [4:0] mm, input logic ps,
                          input logic [1:0] st);
    chk({tag, "_abcd"}, 32'(ab), 32'd0);
    chk({tag, "_busy"}, 32'(bz), 32'd0);
    chk({tag, "_done"}, 32'(dn), 32'd0);
    chk({tag, "_table"}, 32'(t), 32'd0);
    chk({tag, "_mismatch"}, 32'(mm), 32'd0);
    chk({tag, "_pass"}, 32'(ps), 32'd0);
    chk({tag, "_state"}, 32'(st), 32'd0);
  endtask

  initial begin
    int da;
    repeat (2) @(negedge clk);
    chk_zero("rst_a", abcd_a, busy_a, done_a, tbl_a, mm_a, pass_a, st_a);
    chk_zero("rst_b", abcd_b, busy_b, done_b, tbl_b, mm_b, pass_b, st_b);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Matching table, then confirm pass and abcd are held in IDLE
    go_a(16'h1894, 1'b0);
    wait_done(1'b0, 60);
    repeat (3) @(negedge clk);
    chk("a_pass_held", 32'(pass_a), 32'd1);
    chk("a_abcd_held", 32'(abcd_a), 32'd15);
    chk("a_busy_idle", 32'(busy_a), 32'd0);

    go_a(16'h1895, 1'b0);
    wait_done(1'b0, 60);
    chk("a_pass_cleared", 32'(pass_a), 32'd0);

    go_a(16'h0000, 1'b1);
    wait_done(1'b0, 60);
    one_a = 1'b0;

    // SETTLE=3 with a delayed unit
    @(negedge clk);
    exp_b    = 16'h1894;
    start_b  = 1'b1;
    b_c0     = cyc;
    b_active = 1'b1;
    exp_b_q.push_back(model(16'h1894, 1'b0, cyc, 3));
    @(negedge clk);
    start_b = 1'b0;
    wait_done(1'b1, 100);
    b_active = 1'b0;

    // Mid-sweep start pulse and expected change must be ignored
    da = done_a_cnt;
    go_a(16'h1895, 1'b0);
    wait_abcd_a(4'd5);
    start_a = 1'b1;
    exp_a   = 16'h0000;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, 60);
    repeat (40) @(negedge clk);
    chk("a_single_done", 32'(done_a_cnt - da), 32'd1);

    // Asynchronous reset in the middle of vector 9
    go_a(16'h1894, 1'b0);
    wait_abcd_a(4'd9);
    #1 rst = 1'b1;
    void'(exp_a_q.pop_back());
    #1;
    chk_zero("abort_a", abcd_a, busy_a, done_a, tbl_a, mm_a, pass_a, st_a);
    chk("abort_b_table", 32'(tbl_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    go_a(16'h1894, 1'b0);
    wait_done(1'b0, 60);
    chk("a_pass_after_abort", 32'(pass_a), 32'd1);

    repeat (5) @(negedge clk);
    chk("a_queue_empty", 32'(exp_a_q.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_b_q.size()), 32'd0);
    chk("a_done_count", 32'(done_a_cnt), 32'd5);
    chk("b_done_count", 32'(done_b_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
